// File: rtl/icache_assoc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icache_assoc
//   N-way set-associative instruction cache between the fetch stage and a
//   16-bit Wishbone instruction bus. Hits come out of synchronous tag/data
//   RAMs one cycle after the request is taken. Misses refill a whole line with
//   a Wishbone burst and forward the requested instruction on the last ack.
//   Replacement is per-set tree pseudo-LRU, flush clears every valid bit in a
//   single cycle, and saturating hit/miss counters are provided.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   mem_req                fetch stage can accept an instruction
//   mem_ppl_submit         new address on mem_addr
//   mem_addr               instruction address
//   mem_ack / mem_data     one-cycle instruction return
//   i_flush / flush_busy   invalidate all lines / flush held until refill ends
//   wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_i_dat, wb_ack   Wishbone master
//   stat_hits, stat_misses saturating statistics counters
// -----------------------------------------------------------------------------
module icache_assoc #(
    parameter int         WAYS       = 4,
    parameter int         SETS       = 32,
    parameter int         LINE_INSTR = 4,
    parameter int         ADDR_W     = 16,
    parameter logic [7:0] WB_PREFIX  = 8'h01,
    parameter int         CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              mem_req,
    input  logic              mem_ppl_submit,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ack,
    output logic [31:0]       mem_data,
    input  logic              i_flush,
    output logic              flush_busy,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [1:0]        wb_sel,
    output logic [23:0]       wb_adr,
    input  logic [15:0]       wb_i_dat,
    input  logic              wb_ack,
    output logic [CNT_W-1:0]  stat_hits,
    output logic [CNT_W-1:0]  stat_misses
);

    localparam int OFF_W   = $clog2(LINE_INSTR);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int BURST_W = OFF_W + 1;
    localparam int WAY_W   = $clog2(WAYS);
    localparam int WORDS   = 2 * LINE_INSTR;
    localparam int LINE_W  = 32 * LINE_INSTR;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

    // Tree PLRU: node n (1-based heap order) is stored in bit n-1 and points
    // at the subtree holding the next victim (0 = lower half, 1 = upper half).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int               node;
        logic [WAY_W-1:0] way;
        node = 1;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            way[WAY_W-1-l] = bits[node-1];
            node           = 2 * node + int'(bits[node-1]);
        end
        return way;
    endfunction

    // Point every node on the path to 'way' away from it.
    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
        int              node;
        logic [WAYS-2:0] nb;
        node = 1;
        nb   = bits;
        for (int l = 0; l < WAY_W; l++) begin
            nb[node-1] = ~way[WAY_W-1-l];
            node       = 2 * node + int'(way[WAY_W-1-l]);
        end
        return nb;
    endfunction

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_pend_addr;
    logic                 r_pend_valid;
    logic [BURST_W-1:0]   r_cnt;
    logic [LINE_W-1:0]    r_buf;
    logic [WAY_W-1:0]     r_victim;
    logic                 r_flush_pend;
    logic [CNT_W-1:0]     r_hits;
    logic [CNT_W-1:0]     r_misses;
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-2:0]      r_plru  [SETS];

    logic                 w_take;
    logic [ADDR_W-1:0]    w_take_addr;
    logic [IDX_W-1:0]     w_take_idx;
    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [OFF_W-1:0]     w_off;
    logic [WAYS-1:0]      w_hit_vec;
    logic [WAY_W-1:0]     w_hit_way;
    logic [WAY_W-1:0]     w_victim;
    logic                 w_lookup_hit;
    logic                 w_lookup_miss;
    logic                 w_fill_last;
    logic [LINE_W-1:0]    w_fill_line;
    logic [LINE_W-1:0]    w_sel_line;
    logic [WAYS-1:0][LINE_W-1:0] w_data_rd;

    // A parked address (submitted while stalled) always goes ahead of a live one.
    assign w_take      = (r_state == S_IDLE) && mem_req && (r_pend_valid || mem_ppl_submit);
    assign w_take_addr = r_pend_valid ? r_pend_addr : mem_addr;
    assign w_take_idx  = w_take_addr[OFF_W +: IDX_W];

    assign w_off = r_addr[OFF_W-1:0];
    assign w_idx = r_addr[OFF_W +: IDX_W];
    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];

    assign w_lookup_hit  = (r_state == S_LOOKUP) && (|w_hit_vec);
    assign w_lookup_miss = (r_state == S_LOOKUP) && !(|w_hit_vec);
    assign w_fill_last   = (r_state == S_REFILL) && wb_ack && (r_cnt == BURST_W'(WORDS - 1));

    // ---------------------------------------------------------------- ways
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0]  r_tag_ram  [SETS];
        logic [LINE_W-1:0] r_data_ram [SETS];
        logic [TAG_W-1:0]  r_tag_q;
        logic [LINE_W-1:0] r_data_q;

        // Writes only happen in REFILL and reads only on a take from IDLE,
        // so the two ports never collide.
        always_ff @(posedge i_clk) begin
            if (w_fill_last && (r_victim == WAY_W'(gi))) begin
                r_tag_ram[w_idx]  <= w_tag;
                r_data_ram[w_idx] <= w_fill_line;
            end
            if (w_take) begin
                r_tag_q  <= r_tag_ram[w_take_idx];
                r_data_q <= r_data_ram[w_take_idx];
            end
        end

        assign w_data_rd[gi] = r_data_q;
        assign w_hit_vec[gi] = r_valid[w_idx][gi] && (r_tag_q == w_tag);
    end

    // Lowest hitting way wins; lowest invalid way is preferred as victim.
    always_comb begin
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        end
    end

    always_comb begin
        w_victim = plru_victim(r_plru[w_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
        end
    end

    // The final bus word is still on wb_i_dat during the last ack.
    always_comb begin
        w_fill_line                  = r_buf;
        w_fill_line[LINE_W-1 -: 16]  = wb_i_dat;
    end

    always_comb begin
        w_sel_line = (r_state == S_REFILL) ? w_fill_line : w_data_rd[w_hit_way];
        mem_data   = w_sel_line[32*w_off +: 32];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        mem_ack      = 1'b0;
        wb_cyc       = 1'b0;
        wb_stb       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                mem_ack      = w_lookup_hit;
                w_state_next = w_lookup_hit ? S_IDLE : S_REFILL;
            end
            S_REFILL: begin
                wb_cyc  = 1'b1;
                wb_stb  = 1'b1;
                mem_ack = w_fill_last;
                if (w_fill_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_pend_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_victim     <= '0;
        end else begin
            if (w_take) r_addr <= w_take_addr;

            if (w_take) begin
                // A new submit arriving while the parked one is taken re-parks.
                if (r_pend_valid && mem_ppl_submit) r_pend_addr <= mem_addr;
                else                                r_pend_valid <= 1'b0;
            end else if (mem_ppl_submit) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= mem_addr;
            end

            if (w_lookup_miss) r_victim <= w_victim;

            if ((r_state == S_REFILL) && wb_ack) begin
                r_buf[16*r_cnt +: 16] <= wb_i_dat;
                r_cnt                 <= w_fill_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Valid bits, PLRU state, flush tracking and statistics.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_flush_pend <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            if (w_fill_last) begin
                // A flush seen during the burst also discards the new line.
                if (r_flush_pend || i_flush) begin
                    for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                end else begin
                    r_valid[w_idx][r_victim] <= 1'b1;
                end
            end else if (i_flush && (r_state != S_REFILL)) begin
                for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
            end

            if (w_lookup_hit)     r_plru[w_idx] <= plru_update(r_plru[w_idx], w_hit_way);
            else if (w_fill_last) r_plru[w_idx] <= plru_update(r_plru[w_idx], r_victim);

            if (w_fill_last)                             r_flush_pend <= 1'b0;
            else if ((r_state == S_REFILL) && i_flush)   r_flush_pend <= 1'b1;

            if (w_lookup_hit && (r_hits != '1))    r_hits   <= r_hits + 1'b1;
            if (w_lookup_miss && (r_misses != '1)) r_misses <= r_misses + 1'b1;
        end
    end

    assign flush_busy  = r_flush_pend;
    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
    assign wb_we       = 1'b0;
    assign wb_sel      = 2'b11;
    assign wb_adr      = {WB_PREFIX, 16'({r_addr[ADDR_W-1:OFF_W], r_cnt})};

endmodule
